// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// and the ALU/PC select codes also used by ALUControl and the datapath top.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
           (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_ADDI) ||
           (opcode == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath: per-state selects/enables,
// memory-ready handshake, retired-instruction counter and illegal-opcode pulse.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] retired
);

  state_t             state_reg, state_next;
  logic               illegal_reg;
  logic [COUNT_W-1:0] retired_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // instr_done is already forced low under reset, so an aborted instruction never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= (state_reg == DECODE) && !is_legal_op(op);
      if (instr_done) begin
        retired_reg <= retired_reg + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:     state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_next = MEM_ADR;
          OP_RTYPE:       state_next = R_EXEC;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_ADDI:        state_next = ADDI_EXEC;
          OP_J:           state_next = JUMP;
          default:        state_next = FETCH;
        endcase
      end
      MEM_ADR: begin
        if (op == OP_LW) begin
          state_next = MEM_RD;
        end else if (op == OP_SW) begin
          state_next = MEM_WR;
        end else begin
          state_next = FETCH;
        end
      end
      MEM_RD:    state_next = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:    state_next = mem_ready ? FETCH : MEM_WR;
      R_EXEC:    state_next = R_WB;
      ADDI_EXEC: state_next = ADDI_WB;
      default:   state_next = FETCH;
    endcase
  end

  // Reset masks every output so an interrupted access drops its request in the same cycle.
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALU_B_REG;
    alu_op     = ALU_OP_ADD;
    pc_src     = PC_SRC_ALU;
    instr_done = 1'b0;
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = ALU_B_IMM_SH;
        end
        MEM_ADR, ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ALU_B_IMM;
        end
        MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        MEM_WB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNCT;
        end
        R_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_OP_SUB;
          pc_src     = PC_SRC_ALUOUT;
          instr_done = 1'b1;
          pc_write   = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
        end
        ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_src     = PC_SRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state      = state_reg;
  assign illegal_op = illegal_reg;
  assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle bench for multicycle_control with hand-computed
// state sequences, output selects and retired counts.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [31:0] retired;

  int checks_cnt = 0;
  int errors_cnt = 0;

  multicycle_control #(.COUNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks_cnt++;
    if (obs !== exp_val) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
    end
  endtask

  // Outputs are sampled 1-2 time units after the rising edge, never on it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic z, input logic r);
    op = o;
    zero = z;
    mem_ready = r;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    op = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b1;

    // Reset held for two cycles with mem_ready high: Mealy enables must stay masked.
    tick();
    check("rst_state", state, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_ir_write", ir_write, 0);
    tick();
    check("rst_pc_write", pc_write, 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal_op, 0);
    rst = 1'b0;
    drive(6'b000000, 1'b0, 1'b1);

    // R-type: 0,1,6,7,0
    check("r_fetch_state", state, 0);
    check("r_fetch_mem_read", mem_read, 1);
    check("r_fetch_ir_write", ir_write, 1);
    check("r_fetch_alub", alu_src_b, 2'b01);
    tick();
    check("r_decode_state", state, 1);
    check("r_decode_alub", alu_src_b, 2'b11);
    tick();
    check("r_exec_state", state, 6);
    check("r_exec_aluop", alu_op, 2'b10);
    check("r_exec_srca", alu_src_a, 1);
    check("r_exec_regwrite", reg_write, 0);
    tick();
    check("r_wb_state", state, 7);
    check("r_wb_regwrite", reg_write, 1);
    check("r_wb_regdst", reg_dst, 1);
    check("r_wb_done", instr_done, 1);
    tick();
    check("r_end_state", state, 0);
    check("r_retired", retired, 1);
    $display("txn rtype retired=%0d", retired);

    // lw with two wait cycles in MEM_RD: 7 cycles total
    drive(6'b100011, 1'b0, 1'b1);
    check("lw_fetch_state", state, 0);
    tick();
    check("lw_decode_state", state, 1);
    tick();
    check("lw_adr_state", state, 2);
    check("lw_adr_alub", alu_src_b, 2'b10);
    check("lw_adr_srca", alu_src_a, 1);
    tick();
    drive(6'b100011, 1'b0, 1'b0);
    check("lw_rd1_state", state, 3);
    check("lw_rd1_iord", iord, 1);
    check("lw_rd1_mem_read", mem_read, 1);
    tick();
    check("lw_rd2_state", state, 3);
    tick();
    drive(6'b100011, 1'b0, 1'b1);
    check("lw_rd3_state", state, 3);
    check("lw_rd3_mem_read", mem_read, 1);
    tick();
    check("lw_wb_state", state, 4);
    check("lw_wb_memtoreg", mem_to_reg, 1);
    check("lw_wb_regwrite", reg_write, 1);
    check("lw_wb_regdst", reg_dst, 0);
    tick();
    check("lw_end_state", state, 0);
    check("lw_retired", retired, 2);
    $display("txn lw retired=%0d", retired);

    // beq taken, beq not taken, bne taken
    for (int i = 0; i < 3; i++) begin
      logic [5:0] bop;
      logic       bz;
      logic       exp_pcw;
      bop     = (i == 2) ? 6'b000101 : 6'b000100;
      bz      = (i == 0);
      exp_pcw = (i != 1);
      drive(bop, bz, 1'b1);
      check("br_fetch_state", state, 0);
      tick();
      check("br_decode_state", state, 1);
      tick();
      check("br_state", state, 8);
      check("br_pc_write", pc_write, exp_pcw);
      check("br_pc_src", pc_src, 2'b01);
      check("br_alu_op", alu_op, 2'b01);
      tick();
      check("br_end_state", state, 0);
      check("br_retired", retired, 3 + i);
      $display("txn branch op=%b zero=%0d retired=%0d", bop, bz, retired);
    end

    // j
    drive(6'b000010, 1'b0, 1'b1);
    tick();
    check("j_decode_state", state, 1);
    tick();
    check("j_state", state, 11);
    check("j_pc_write", pc_write, 1);
    check("j_pc_src", pc_src, 2'b10);
    tick();
    check("j_end_state", state, 0);
    $display("txn j retired=%0d", retired);

    // sw
    drive(6'b101011, 1'b0, 1'b1);
    check("sw_fetch_mem_write", mem_write, 0);
    tick();
    check("sw_decode_state", state, 1);
    tick();
    check("sw_adr_state", state, 2);
    check("sw_adr_mem_write", mem_write, 0);
    tick();
    check("sw_wr_state", state, 5);
    check("sw_wr_mem_write", mem_write, 1);
    check("sw_wr_mem_read", mem_read, 0);
    check("sw_wr_iord", iord, 1);
    check("sw_wr_done", instr_done, 1);
    tick();
    check("sw_end_state", state, 0);
    check("j_sw_retired", retired, 7);
    $display("txn sw retired=%0d", retired);

    // Illegal opcode
    drive(6'b111111, 1'b0, 1'b1);
    tick();
    check("ill_decode_state", state, 1);
    check("ill_decode_pulse", illegal_op, 0);
    tick();
    check("ill_back_state", state, 0);
    check("ill_pulse", illegal_op, 1);
    check("ill_reg_write", reg_write, 0);
    check("ill_mem_write", mem_write, 0);
    drive(6'b101011, 1'b0, 1'b1);
    tick();
    check("ill_pulse_end", illegal_op, 0);
    check("ill_retired", retired, 7);
    $display("txn illegal retired=%0d", retired);

    // sw interrupted by reset while stalled in MEM_WR
    tick();
    check("abort_adr_state", state, 2);
    tick();
    drive(6'b101011, 1'b0, 1'b0);
    check("abort_wr_state", state, 5);
    check("abort_wr_done", instr_done, 0);
    tick();
    check("abort_wr_hold", mem_write, 1);
    rst = 1'b1;
    #1;
    check("abort_mem_write", mem_write, 0);
    check("abort_iord", iord, 0);
    tick();
    check("abort_state", state, 0);
    check("abort_retired", retired, 0);
    check("abort_rst_mem_read", mem_read, 0);
    rst = 1'b0;
    #1;
    check("post_fetch_mem_read", mem_read, 1);
    check("post_fetch_ir_write", ir_write, 0);
    $display("txn reset_abort retired=%0d", retired);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath. The datapath uses one shared ALU, a unified instruction/data memory, and IR/MDR/A/B/ALUOut holding registers.
- Replaces the single-cycle main decoder. It issues per-state mux selects and write enables, and handles a memory-ready handshake.
- Keeps a retired-instruction counter and an illegal-opcode flag.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode, IR[31:26]; stable from DECODE until the next FETCH completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable (branch condition already resolved).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- alu_op  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address.
- state  out  4  current state (debug).
- instr_done  out  1  high in the final cycle of each legal instruction.
- illegal_op  out  1  registered one-cycle pulse for an unsupported opcode.
- retired  out  COUNT_W  count of completed legal instructions.

Behaviour:
- Reset:
  - While rst=1: state←FETCH, retired←0, illegal_op←0.
  - While rst=1: all enables (pc_write, mem_read, mem_write, ir_write, reg_write) and instr_done are forced to 0, and all selects are 0.
  - rst mid-instruction aborts it: no partial writes, retired is not incremented.
- Supported opcodes:
  - R-type 000000, lw 100011, sw 101011.
  - beq 000100, bne 000101, addi 001000, j 000010.
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3.
  - MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7.
  - BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, JUMP=11.
  - Codes 12-15 go to FETCH on the next cycle.
- Unlisted outputs are 0 in every state below.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: lw/sw→MEM_ADR, R→R_EXEC, beq/bne→BRANCH, addi→ADDI_EXEC, j→JUMP.
  - Any other opcode→FETCH, and illegal_op=1 in the following cycle.
- MEM_ADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw→MEM_RD, sw→MEM_WR.
- MEM_RD:
  - Outputs: iord=1, mem_read=1.
  - Holds until mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Outputs: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: iord=1, mem_write=1, held until mem_ready.
  - instr_done=mem_ready; goes to FETCH when mem_ready=1.
- R_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: reg_dst=1, reg_write=1, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, instr_done=1.
  - pc_write=(op==beq & zero)|(op==bne & ~zero).
  - Next state: FETCH.
- ADDI_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: ADDI_WB.
- ADDI_WB:
  - Outputs: reg_dst=0, reg_write=1, instr_done=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_src=10, pc_write=1, instr_done=1.
  - Next state: FETCH.
- Latency with mem_ready tied high:
  - beq, bne, j: 3 cycles.
  - R-type, sw, addi: 4 cycles.
  - lw: 5 cycles.
  - Each low cycle of mem_ready in FETCH, MEM_RD or MEM_WR adds one cycle.
- If mem_ready stays low, the FSM stalls indefinitely with the request held and no timeout.
- retired increments by 1 on each clock edge where instr_done=1 and wraps modulo 2^COUNT_W.
- mem_read and mem_write are never both 1.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum;
  - opcode constants;
  - alu_op, alu_src_b and pc_src encodings, shared with ALUControl and the datapath top.
- Single module, no sub-module: the state register, next-state logic, output decode and counter fit in one file.

Test Plan:
- Reset and R-type:
  - Stimulus: hold rst 2 cycles, then op=000000, mem_ready=1.
  - Response: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired=1.
- lw with wait states:
  - Stimulus: op=100011, mem_ready low for 2 cycles in MEM_RD.
  - Response: MEM_RD lasts 3 cycles with iord=1 and mem_read=1; MEM_WB has mem_to_reg=1; 7 cycles total.
- beq / bne:
  - Stimulus: beq with zero=1, then beq with zero=0, then bne with zero=0.
  - Response: in state 8, pc_write=1, 0, 1 respectively; pc_src=01 each time; 3 cycles each.
- j and sw:
  - Stimulus: op=000010, then op=101011 with mem_ready=1.
  - Response: JUMP has pc_write=1 and pc_src=10; sw asserts mem_write only in MEM_WR; retired increments by 2.
- Illegal opcode:
  - Stimulus: op=111111.
  - Response: DECODE→FETCH; illegal_op=1 for exactly 1 cycle; no reg_write or mem_write; retired unchanged.
- Reset mid-instruction:
  - Stimulus: assert rst while in MEM_WR with mem_ready=0.
  - Response: mem_write=0 in the same cycle; state=0 on the next edge; retired=0.
